// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/response bundle between the execute stage and the iterative multiply/divide unit.
// Latency: none, wires only.
// Backpressure: request side is valid/ready (in_valid/in_ready), result side is valid/ready (out_valid/out_ready).
// Signals: in_valid, in_ready, op, rs1_data, rs2_data, rd, flush (request side);
//          out_valid, out_ready, out_rd, out_data, illegal (result side).
// master = execute stage / writeback side, slave = mdu_iter.
interface mdu_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        illegal;

    modport master (
        output in_valid, op, rs1_data, rs2_data, rd, flush, out_ready,
        input  in_ready, out_valid, out_rd, out_data, illegal
    );

    modport slave (
        input  in_valid, op, rs1_data, rs2_data, rd, flush, out_ready,
        output in_ready, out_valid, out_rd, out_data, illegal
    );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide, one shift-add or restoring shift-subtract step per cycle.
// Latency: out_valid rises 33 clk edges after the accept edge (accept edge counted as the 1st).
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready; flush cancels.
// Build option: MDU_DIV_EN defined includes the divider; undefined, ops 4-7 finish on the accept
//   edge with out_data 0 and illegal 1.
// Ports: clk, rst_n (synchronous, active-low), bus (mdu_iter_if.slave: in_valid/in_ready, op,
//   rs1_data, rs2_data, rd, flush, out_valid/out_ready, out_rd, out_data, illegal).
module mdu_iter (
    input  logic      clk,
    input  logic      rst_n,
    mdu_iter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
`ifdef MDU_DIV_EN
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;
`endif

    state_t      state;
    state_t      state_nxt;

    // Operation context captured on the accept edge
    logic [4:0]  cnt;
    logic [1:0]  op_q;
`ifdef MDU_DIV_EN
    logic        div_q;
`endif
    logic        neg_q;
    logic [4:0]  rd_q;

    // Shared iteration registers: multiply keeps {hi,lo} as the shifting product with the
    // multiplier in lo; divide keeps hi as the partial remainder and lo as dividend/quotient.
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] opb;

    // Result registers
    logic [31:0] res_q;
    logic        ill_q;

    logic        accept;
    logic        a_neg;
    logic        b_neg;
    logic        neg_in;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    logic [31:0] step_hi;
    logic [31:0] step_lo;
    logic [32:0] mul_sum;
    logic [63:0] prod;
    logic [63:0] prod_s;
    logic [31:0] mul_res;
    logic [31:0] fin;
`ifdef MDU_DIV_EN
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic [31:0] div_sel;
    logic [31:0] div_res;
`endif

    // flush wins over a simultaneous request
    assign accept = bus.in_valid && (state == IDLE) && !bus.flush;

    // Operand interpretation and result-sign decode for the incoming request
    always_comb begin
        a_neg  = 1'b0;
        b_neg  = 1'b0;
        neg_in = 1'b0;
        case (bus.op)
            OP_MULH: begin
                a_neg  = bus.rs1_data[31];
                b_neg  = bus.rs2_data[31];
                neg_in = a_neg ^ b_neg;
            end
            OP_MULHSU: begin
                a_neg  = bus.rs1_data[31];
                neg_in = a_neg;
            end
`ifdef MDU_DIV_EN
            OP_DIV: begin
                a_neg  = bus.rs1_data[31];
                b_neg  = bus.rs2_data[31];
                // Divide by zero must return all-ones regardless of operand signs
                neg_in = (a_neg ^ b_neg) && (bus.rs2_data != 32'd0);
            end
            OP_REM: begin
                a_neg  = bus.rs1_data[31];
                b_neg  = bus.rs2_data[31];
                neg_in = a_neg;
            end
`endif
            default: ;
        endcase
        a_mag = a_neg ? (~bus.rs1_data + 32'd1) : bus.rs1_data;
        b_mag = b_neg ? (~bus.rs2_data + 32'd1) : bus.rs2_data;
    end

    // One iteration step plus the final sign fix-up applied on the CALC->DONE edge
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : 33'd0);
        step_hi = mul_sum[32:1];
        step_lo = {mul_sum[0], lo[31:1]};
`ifdef MDU_DIV_EN
        div_shift = {hi, lo[31]};
        // hi < divisor holds throughout, so a 34-bit difference never overflows
        div_diff  = {1'b0, div_shift} - {2'b00, opb};
        if (div_q) begin
            if (!div_diff[33]) begin
                step_hi = div_diff[31:0];
                step_lo = {lo[30:0], 1'b1};
            end else begin
                step_hi = div_shift[31:0];
                step_lo = {lo[30:0], 1'b0};
            end
        end
`endif
        prod    = {step_hi, step_lo};
        prod_s  = neg_q ? (~prod + 64'd1) : prod;
        mul_res = (op_q == 2'b00) ? prod_s[31:0] : prod_s[63:32];
`ifdef MDU_DIV_EN
        // op bit 1 selects remainder (REM/REMU) over quotient (DIV/DIVU)
        div_sel = op_q[1] ? step_hi : step_lo;
        div_res = neg_q ? (~div_sel + 32'd1) : div_sel;
        fin     = div_q ? div_res : mul_res;
`else
        fin     = mul_res;
`endif
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef MDU_DIV_EN
                    state_nxt = CALC;
`else
                    state_nxt = bus.op[2] ? DONE : CALC;
`endif
                end
            end
            CALC: begin
                if (cnt == 5'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) begin
            state_nxt = IDLE;
        end
    end

    // FSM: outputs
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.out_rd    = rd_q;
        bus.out_data  = res_q;
        bus.illegal   = ill_q;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= 5'd0;
            op_q  <= 2'd0;
`ifdef MDU_DIV_EN
            div_q <= 1'b0;
`endif
            neg_q <= 1'b0;
            rd_q  <= 5'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            opb   <= 32'd0;
            res_q <= 32'd0;
            ill_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= bus.op[1:0];
`ifdef MDU_DIV_EN
                        div_q <= bus.op[2];
                        ill_q <= 1'b0;
`else
                        ill_q <= bus.op[2];
`endif
                        neg_q <= neg_in;
                        rd_q  <= bus.rd;
                        hi    <= 32'd0;
                        lo    <= a_mag;
                        opb   <= b_mag;
                        cnt   <= 5'd31;
                        res_q <= 32'd0;
                    end
                end
                CALC: begin
                    hi  <= step_hi;
                    lo  <= step_lo;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        res_q <= fin;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed vectors for mdu_iter with hand-computed results.
// Latency: checks exact accept-to-out_valid edge count.
// Backpressure: exercises out_ready stall, flush and mid-operation reset.
module tb_mdu_iter;
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   edges;
    int   seen;

    always #5 clk = ~clk;

    mdu_iter_if bus ();

    mdu_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents a request at a negedge and returns at the negedge after the accept edge
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        bus.op       = op;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.rd       = rd;
        bus.in_valid = 1'b1;
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Counts edges from the accept edge (edge 1) until out_valid is seen; bounded
    task automatic wait_done(output int n);
        n = 1;
        while (!bus.out_valid && n < 80) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_data);
        logic [31:0] e_data;
        logic [31:0] e_ill;
        int          e_lat;
        int          n;
        if (op[2] && !DIV_EN) begin
            e_data = 32'd0;
            e_ill  = 32'd1;
            e_lat  = 1;
        end else begin
            e_data = exp_data;
            e_ill  = 32'd0;
            e_lat  = 33;
        end
        start_op(op, a, b, rd);
        wait_done(n);
        check({tag, "_lat"}, n, e_lat);
        check({tag, "_data"}, bus.out_data, e_data);
        check({tag, "_rd"}, 32'(bus.out_rd), 32'(rd));
        check({tag, "_ill"}, 32'(bus.illegal), e_ill);
        tick();
        check({tag, "_rdy_after"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_vld_after"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.op       = 3'd0;
        bus.rs1_data = 32'd0;
        bus.rs2_data = 32'd0;
        bus.rd       = 5'd0;
        bus.flush    = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_rd", 32'(bus.out_rd), 32'd0);
        check("rst_illegal", 32'(bus.illegal), 32'd0);
        rst_n = 1'b1;
        tick();

        // Multiply
        run_op("mul_7xm3",     OP_MUL,    32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
        run_op("mul_rd0",      OP_MUL,    32'h1234,     32'h10,        5'd0,  32'h0001_2340);
        run_op("mulh_min",     OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd7, 32'h4000_0000);
        run_op("mulhu_max",    OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE);
        run_op("mulhsu_m1x2",  OP_MULHSU, 32'hFFFF_FFFF, 32'd2,        5'd9,  32'hFFFF_FFFF);
        run_op("mulhu_small",  OP_MULHU,  32'h1234_5678, 32'h10,       5'd10, 32'h0000_0001);

        // Divide (illegal/zero in builds without the divider)
        run_op("div_m7d2",     OP_DIV,    32'hFFFF_FFF9, 32'd2,        5'd11, 32'hFFFF_FFFD);
        run_op("rem_m7d2",     OP_REM,    32'hFFFF_FFF9, 32'd2,        5'd12, 32'hFFFF_FFFF);
        run_op("div_ovf",      OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
        run_op("rem_ovf",      OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000);
        run_op("divu_by0",     OP_DIVU,   32'd100,      32'd0,         5'd15, 32'hFFFF_FFFF);
        run_op("remu_by0",     OP_REMU,   32'd100,      32'd0,         5'd16, 32'd100);
        run_op("div_m7by0",    OP_DIV,    32'hFFFF_FFF9, 32'd0,        5'd17, 32'hFFFF_FFFF);
        run_op("rem_m7by0",    OP_REM,    32'hFFFF_FFF9, 32'd0,        5'd18, 32'hFFFF_FFF9);
        run_op("divu_1000d7",  OP_DIVU,   32'd1000,     32'd7,         5'd19, 32'd142);
        run_op("remu_1000d7",  OP_REMU,   32'd1000,     32'd7,         5'd20, 32'd6);
        run_op("div_7dm2",     OP_DIV,    32'd7,        32'hFFFF_FFFE, 5'd21, 32'hFFFF_FFFD);
        run_op("rem_7dm2",     OP_REM,    32'd7,        32'hFFFF_FFFE, 5'd22, 32'd1);

        // Result stall: outputs hold for 5 cycles with out_ready low
        bus.out_ready = 1'b0;
        start_op(OP_MUL, 32'd3, 32'd4, 5'd9);
        wait_done(edges);
        check("stall_lat", edges, 33);
        for (int i = 0; i < 5; i++) begin
            check("stall_vld", 32'(bus.out_valid), 32'd1);
            check("stall_data", bus.out_data, 32'd12);
            check("stall_rd", 32'(bus.out_rd), 32'd9);
            check("stall_ill", 32'(bus.illegal), 32'd0);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        check("release_vld", 32'(bus.out_valid), 32'd0);

        // flush together with a request: nothing is accepted
        bus.op       = OP_MUL;
        bus.rs1_data = 32'd2;
        bus.rs2_data = 32'd2;
        bus.rd       = 5'd3;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        check("flush_vs_accept", 32'(bus.in_ready), 32'd1);

        // flush in the 10th CALC cycle: the op never produces a result
        start_op(OP_MUL, 32'd5, 32'd6, 5'd3);
        repeat (9) tick();
        check("calc_in_ready", 32'(bus.in_ready), 32'd0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        seen = 0;
        repeat (40) begin
            if (bus.out_valid) seen++;
            tick();
        end
        check("flush_no_valid", seen, 0);

        // Reset in the 20th CALC cycle
        start_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
        repeat (19) tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out_data", bus.out_data, 32'd0);
        check("mid_rst_out_rd", 32'(bus.out_rd), 32'd0);
        check("mid_rst_illegal", 32'(bus.illegal), 32'd0);
        rst_n = 1'b1;
        tick();
        run_op("mul_after_rst", OP_MUL, 32'd6, 32'd7, 5'd4, 32'd42);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
